axi_reg_slave: RTL and testbench
================================

# axi_reg_slave

Bus-to-register bridge on the slave side of the `axi_bus` interface. It accepts address, write-data and read-data handshakes from a bus master and converts each transaction into a single-cycle register write or read strobe. The strobes drive the timer register file directly downstream. It processes one transaction at a time and has no outstanding-transaction buffering.

## Interface
- `AXI_ADDR_WIDTH`, default 32: bus address parameter; the ADDR port is `AXI_ADDR_WIDTH+1` bits wide (`[AXI_ADDR_WIDTH:0]`).
- `AXI_DATA_WIDTH`, default 32: bus and register data width.
- `REG_ADDR_WIDTH`, default 4: register index width, giving 2^REG_ADDR_WIDTH 32-bit word registers.
- `WTIMEOUT`, default 255: write-data wait limit in cycles, range 1..255. Used only with the macro enabled.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ADDR` in AXI_ADDR_WIDTH+1: byte address.
- `AVALID` in 1 / `AREADY` out 1: address handshake.
- `AWRITE` in 1: 1 = write, 0 = read; sampled with the address.
- `WVALID` in 1 / `WREADY` out 1 / `WDATA` in AXI_DATA_WIDTH: write data handshake.
- `RVALID` out 1 / `RREADY` in 1 / `RDATA` out AXI_DATA_WIDTH: read data handshake.
- `reg_addr` out REG_ADDR_WIDTH: latched register index.
- `reg_wdata` out AXI_DATA_WIDTH: latched write data.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in AXI_DATA_WIDTH: register file read data, valid the cycle after `reg_re`.
- `err` out 1: one-cycle pulse on a decode error or timeout.

## Operation
- FSM states: IDLE, W_DATA, RD_REQ, RD_WAIT, RD_RESP.
- IDLE:
  - `AREADY`=1, decoded from state.
  - On `AVALID`&`AREADY`, latch the index `ADDR[REG_ADDR_WIDTH+1:2]` into `reg_addr` and latch the hit flag.
  - Go to W_DATA if `AWRITE`=1, otherwise to RD_REQ.
- Decode hit: `ADDR[1:0]`==0 and `ADDR[AXI_ADDR_WIDTH:REG_ADDR_WIDTH+2]`==0.
- W_DATA:
  - `WREADY`=1.
  - On `WVALID`, latch `WDATA` into `reg_wdata` and go to IDLE.
  - Next cycle: `reg_we`=1 if hit; if miss, `reg_we` stays 0 and `err`=1. The data is discarded on a miss, but the handshake still completes.
- RD_REQ: `reg_re`=hit for one cycle, then go to RD_WAIT.
- RD_WAIT:
  - Capture `reg_rdata` into `RDATA` if hit; capture 0 and pulse `err` if miss.
  - Set `RVALID` and go to RD_RESP.
- RD_RESP:
  - `RVALID`=1 and `RDATA` held stable until `RREADY`.
  - On `RVALID`&`RREADY`, clear `RVALID` and go to IDLE.
- `AREADY`, `WREADY` and `RVALID` are never asserted simultaneously.
- Reset mid-transaction: asynchronous return to IDLE. The pending transaction is dropped, no strobe is issued, and the master must reissue it.
- `WDATA` presented while the FSM is in IDLE or a read state is ignored.

## Timing
Reset values:
- `AREADY`=1 (IDLE).
- `WREADY`, `RVALID`, `reg_we`, `reg_re` and `err` = 0.
- `RDATA`, `reg_addr` and `reg_wdata` = 0.

Write sequence:
- Address accepted at edge T0.
- `WREADY`=1 from T0+1.
- Data accepted at edge Tn.
- `reg_we`=1 during cycle Tn+1, the same cycle that `AREADY`=1 again.
- Back-to-back minimum: 2 cycles per write.

Read sequence:
- Address accepted at T0.
- `reg_re` high in cycle T0+1.
- `reg_rdata` sampled at the end of T0+2.
- `RVALID`=1 from T0+3.
- Minimum latency from address to data: 3 cycles.
- `AREADY`=1 the cycle after the RREADY handshake.

Other timing rules:
- `WVALID` asserted in the same cycle that `WREADY` first rises is accepted at that edge.
- `RREADY` held high in advance completes the handshake in the first RVALID cycle.

## Configuration
- Macro `AXI_REG_SLAVE_WTIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on entry to W_DATA and increments every W_DATA cycle without `WVALID`.
  - When it reaches `WTIMEOUT` with no `WVALID`, the FSM aborts to IDLE: `err`=1 for one cycle and `reg_we` is not issued.
  - `WVALID` arriving in the same cycle the count reaches `WTIMEOUT` wins: the write completes normally.
- Undefined: W_DATA waits indefinitely; the counter logic is not present.

## Test plan
- Write 0x0000_0010 with WDATA 0xA5A5_1234 and WVALID one cycle after WREADY rises -> `reg_we`=1 for exactly one cycle with `reg_addr`=4 and `reg_wdata`=0xA5A5_1234; `err`=0.
- Read 0x0000_0008 with `reg_rdata`=0x0000_00FF and RREADY held low for 5 cycles -> `reg_re` pulses once with `reg_addr`=2; `RVALID` rises 3 cycles after address acceptance; `RDATA`=0xFF stays stable for all 5 stall cycles; `AREADY`=1 the cycle after the RREADY handshake.
- Misaligned write to 0x0000_0006 and out-of-range read of 0x0000_0100 (REG_ADDR_WIDTH=4) -> no `reg_we`; write handshake completes; read returns `RDATA`=0; `err` pulses once per transaction.
- Async `rst_n` low while in RD_RESP and while in W_DATA -> all outputs at their reset values immediately; no strobe afterwards; `AREADY`=1 after release.
- With `AXI_REG_SLAVE_WTIMEOUT_EN` and WTIMEOUT=4, withhold WVALID -> abort after 4 W_DATA cycles with `err`=1 and no `reg_we`. A second run with WVALID in the 4th cycle -> normal write.
- Without the macro, withhold WVALID for 1000 cycles -> `WREADY` held at 1 throughout; the write completes normally when WVALID finally arrives.

Source files
------------

// File: rtl/axi_reg_slave.sv
// axi_reg_slave: bus-to-register bridge, one transaction at a time.
// Optional write-data timeout: define AXI_REG_SLAVE_WTIMEOUT_EN.
module axi_reg_slave #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int WTIMEOUT       = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [AXI_ADDR_WIDTH:0]   ADDR,
   input  logic                      AVALID,
   output logic                      AREADY,
   input  logic                      AWRITE,
   input  logic                      WVALID,
   output logic                      WREADY,
   input  logic [AXI_DATA_WIDTH-1:0] WDATA,
   output logic                      RVALID,
   input  logic                      RREADY,
   output logic [AXI_DATA_WIDTH-1:0] RDATA,
   output logic [REG_ADDR_WIDTH-1:0] reg_addr,
   output logic [AXI_DATA_WIDTH-1:0] reg_wdata,
   output logic                      reg_we,
   output logic                      reg_re,
   input  logic [AXI_DATA_WIDTH-1:0] reg_rdata,
   output logic                      err
);

   typedef enum logic [2:0] {
      IDLE,
      W_DATA,
      RD_REQ,
      RD_WAIT,
      RD_RESP
   } state_t;

   state_t state, next;
   logic   hit;
   logic   hit_d;
   logic   a_fire;
   logic   w_fire;
   logic   wto;

   assign hit_d = (ADDR[1:0] == 2'b00) &&
                  (ADDR[AXI_ADDR_WIDTH:REG_ADDR_WIDTH+2] == '0);
   assign a_fire = AVALID && AREADY;
   assign w_fire = (state == W_DATA) && WVALID;

`ifdef AXI_REG_SLAVE_WTIMEOUT_EN
   logic [7:0] wcnt;

   // fire on the last allowed idle W_DATA cycle; WVALID then wins
   assign wto = (state == W_DATA) && !WVALID &&
                (wcnt == 8'(WTIMEOUT - 1));

   // wait counter: cleared outside W_DATA, counts idle W_DATA cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wcnt <= '0;
      else if (state != W_DATA)
         wcnt <= '0;
      else if (!WVALID)
         wcnt <= wcnt + 8'd1;
   end
`else
   // no timeout path: W_DATA waits for WVALID indefinitely
   assign wto = (WTIMEOUT < 0);
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next;
   end

   // next-state logic
   always_comb begin
      next = state;
      unique case (state)
         IDLE:    if (AVALID) next = AWRITE ? W_DATA : RD_REQ;
         W_DATA:  if (WVALID || wto) next = IDLE;
         RD_REQ:  next = RD_WAIT;
         RD_WAIT: next = RD_RESP;
         RD_RESP: if (RREADY) next = IDLE;
         default: next = IDLE;
      endcase
   end

   // handshake outputs and read strobe decoded from state
   always_comb begin
      AREADY = 1'b0;
      WREADY = 1'b0;
      RVALID = 1'b0;
      reg_re = 1'b0;
      unique case (state)
         IDLE:    AREADY = 1'b1;
         W_DATA:  WREADY = 1'b1;
         RD_REQ:  reg_re = hit;
         RD_WAIT: ;
         RD_RESP: RVALID = 1'b1;
         default: ;
      endcase
   end

   // latch register index and decode result with the address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_addr <= '0;
         hit      <= 1'b0;
      end else if (a_fire) begin
         reg_addr <= ADDR[REG_ADDR_WIDTH+1:2];
         hit      <= hit_d;
      end
   end

   // latch write data and issue the write strobe the following cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_wdata <= '0;
         reg_we    <= 1'b0;
      end else begin
         reg_we <= w_fire && hit;
         if (w_fire)
            reg_wdata <= WDATA;
      end
   end

   // capture read data one cycle after the read strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         RDATA <= '0;
      else if (state == RD_WAIT)
         RDATA <= hit ? reg_rdata : '0;
   end

   // error pulse: decode miss on either path, or write-data timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 1'b0;
      else
         err <= (w_fire && !hit) ||
                ((state == RD_WAIT) && !hit) ||
                wto;
   end

endmodule

// File: tb/tb_axi_reg_slave.sv
// tb_axi_reg_slave: directed bench with a strobe/response scoreboard.
// A monitor pops queued expectations whenever the DUT strobes or responds.
module tb_axi_reg_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [32:0] ADDR;
   logic        AVALID;
   logic        AREADY;
   logic        AWRITE;
   logic        WVALID;
   logic        WREADY;
   logic [31:0] WDATA;
   logic        RVALID;
   logic        RREADY;
   logic [31:0] RDATA;
   logic [3:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_we;
   logic        reg_re;
   logic [31:0] reg_rdata = '0;
   logic        err;

   int checks = 0;
   int errors = 0;
   int err_seen = 0;
   int err_exp = 0;

   logic [35:0] wq[$];
   logic [3:0]  rq[$];
   logic [31:0] dq[$];

   logic [31:0] mem [16];
   logic [15:0] wflag = '0;

   axi_reg_slave #(
      .AXI_ADDR_WIDTH(32),
      .AXI_DATA_WIDTH(32),
      .REG_ADDR_WIDTH(4),
      .WTIMEOUT(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ADDR(ADDR),
      .AVALID(AVALID),
      .AREADY(AREADY),
      .AWRITE(AWRITE),
      .WVALID(WVALID),
      .WREADY(WREADY),
      .WDATA(WDATA),
      .RVALID(RVALID),
      .RREADY(RREADY),
      .RDATA(RDATA),
      .reg_addr(reg_addr),
      .reg_wdata(reg_wdata),
      .reg_we(reg_we),
      .reg_re(reg_re),
      .reg_rdata(reg_rdata),
      .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int i);
      return (i == 2) ? 32'h0000_00FF : (32'h1000_0000 | i);
   endfunction

   // register file model: data valid the cycle after reg_re
   always @(posedge clk) begin
      if (reg_re)
         reg_rdata <= wflag[reg_addr] ? mem[reg_addr]
                                      : init_val(int'(reg_addr));
      if (reg_we) begin
         mem[reg_addr]   <= reg_wdata;
         wflag[reg_addr] <= 1'b1;
      end
   end

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: compare strobes and read responses against the queues
   initial begin
      logic [35:0] we_e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (reg_we) begin
               if (wq.size() == 0)
                  chk("we_unexpected", reg_we, 0);
               else begin
                  we_e = wq.pop_front();
                  chk("we_addr_data", {reg_addr, reg_wdata}, we_e);
               end
            end
            if (reg_re) begin
               if (rq.size() == 0)
                  chk("re_unexpected", reg_re, 0);
               else
                  chk("re_addr", reg_addr, rq.pop_front());
            end
            if (RVALID && RREADY) begin
               if (dq.size() == 0)
                  chk("rresp_unexpected", RVALID, 0);
               else
                  chk("rdata", RDATA, dq.pop_front());
            end
            if (err)
               err_seen++;
            if (32'(AREADY) + 32'(WREADY) + 32'(RVALID) > 1)
               chk("handshake_excl", {AREADY, WREADY, RVALID}, 0);
         end
      end
   end

   task automatic check_reset();
      chk("rst_ctrl", {AREADY, WREADY, RVALID, reg_we, reg_re, err},
          6'b100000);
      chk("rst_rdata", RDATA, 0);
      chk("rst_reg_addr", reg_addr, 0);
      chk("rst_reg_wdata", reg_wdata, 0);
   endtask

   task automatic addr_phase(input logic [32:0] a, input logic w);
      int n = 0;
      @(posedge clk);
      #1;
      ADDR = a;
      AWRITE = w;
      AVALID = 1'b1;
      @(negedge clk);
      while (!AREADY && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("aready", AREADY, 1);
      @(posedge clk);
      #1;
      AVALID = 1'b0;
   endtask

   task automatic do_write(input logic [32:0] a, input logic [31:0] d,
                           input int dly, input bit hit);
      bit held = 1'b1;
      addr_phase(a, 1'b1);
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         if (!WREADY) held = 1'b0;
         @(posedge clk);
         #1;
      end
      WDATA = d;
      WVALID = 1'b1;
      if (hit) wq.push_back({a[5:2], d});
      if (!hit) err_exp++;
      @(negedge clk);
      chk("wready", WREADY, 1);
      @(posedge clk);
      #1;
      WVALID = 1'b0;
      @(negedge clk);
      chk("w_strobe", {reg_we, err, AREADY}, {hit, !hit, 1'b1});
      if (dly >= 1000) chk("wready_held", held, 1);
   endtask

   task automatic do_read(input logic [32:0] a, input logic [31:0] e,
                          input bit hit, input int stall, input bit early);
      int lat = 0;
      bit stable = 1'b1;
      logic [31:0] ev;
      ev = hit ? e : 32'h0;
      if (hit) rq.push_back(a[5:2]);
      dq.push_back(ev);
      if (!hit) err_exp++;
      RREADY = early;
      addr_phase(a, 1'b0);
      do begin
         @(negedge clk);
         lat++;
      end while (!RVALID && lat < 10);
      chk("r_latency", lat, 3);
      chk("r_err", err, !hit);
      for (int i = 0; i < stall; i++) begin
         if (!RVALID || RDATA !== ev) stable = 1'b0;
         @(posedge clk);
         #1;
         if (i == stall - 1) RREADY = 1'b1;
         @(negedge clk);
      end
      if (stall > 0) chk("r_stable", stable, 1);
      @(posedge clk);
      #1;
      RREADY = 1'b0;
      @(negedge clk);
      chk("r_done", {AREADY, RVALID}, 2'b10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      ADDR = '0;
      AVALID = 1'b0;
      AWRITE = 1'b0;
      WVALID = 1'b0;
      WDATA = '0;
      RREADY = 1'b0;
      #12;
      check_reset();
      @(negedge clk);
      rst_n = 1'b1;

      do_write(33'h10, 32'hA5A5_1234, 1, 1'b1);
      do_read(33'h08, 32'h0000_00FF, 1'b1, 5, 1'b0);
      do_read(33'h10, 32'hA5A5_1234, 1'b1, 0, 1'b1);
      do_write(33'h06, 32'h1111_2222, 0, 1'b0);
      do_read(33'h100, 32'h0, 1'b0, 0, 1'b1);
      do_write(33'h3C, 32'h0000_0011, 0, 1'b1);
      do_write(33'h00, 32'h0000_0022, 0, 1'b1);
      do_read(33'h3C, 32'h0000_0011, 1'b1, 1, 1'b0);
      do_read(33'h00, 32'h0000_0022, 1'b1, 0, 1'b1);

      // reset while in RD_RESP
      rq.push_back(4'd1);
      addr_phase(33'h04, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!RVALID && n < 10);
      chk("rresp_reached", RVALID, 1);
      #2 rst_n = 1'b0;
      #1 check_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      WDATA = 32'hFFFF_FFFF;
      WVALID = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      WVALID = 1'b0;
      @(negedge clk);
      chk("idle_after_rst1", {AREADY, reg_we}, 2'b10);

      // reset while in W_DATA
      addr_phase(33'h08, 1'b1);
      @(negedge clk);
      chk("wdata_reached", WREADY, 1);
      #2 rst_n = 1'b0;
      #1 check_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_after_rst2", {AREADY, reg_we}, 2'b10);

`ifdef AXI_REG_SLAVE_WTIMEOUT_EN
      addr_phase(33'h18, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         if (WREADY) n++;
      end while (WREADY && n < 20);
      chk("to_cycles", n, 4);
      chk("to_abort", {err, AREADY, reg_we}, 3'b110);
      err_exp++;
      do_write(33'h1C, 32'h5555_AAAA, 3, 1'b1);
      do_read(33'h18, 32'h1000_0006, 1'b1, 0, 1'b1);
      do_read(33'h1C, 32'h5555_AAAA, 1'b1, 0, 1'b1);
`else
      do_write(33'h14, 32'hDEAD_BEEF, 1000, 1'b1);
      do_read(33'h14, 32'hDEAD_BEEF, 1'b1, 2, 1'b0);
`endif

      repeat (3) @(negedge clk);
      chk("wq_drained", wq.size(), 0);
      chk("rq_drained", rq.size(), 0);
      chk("dq_drained", dq.size(), 0);
      chk("err_count", err_seen, err_exp);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
